// File: rtl/rx_burst_scheduler.sv
// Ping-pong drain sequencer for the 16-slot receive burst buffer: tracks half occupancy,
// arbitrates writer fills against reader releases and times load/shift/burst/guard-gap strobes.
module rx_burst_scheduler #(
    parameter int BURST_BITS     = 148,
    parameter int SLOTS_PER_HALF = 8,
    parameter int GAP_SHORT      = 8,
    parameter int GAP_LONG       = 9,
    parameter int LONG_EVERY     = 4
) (
    input  logic                              ff_clk,
    input  logic                              ff_rst_n,
    input  logic                              half_wr,
    input  logic                              clr_err,
    output logic                              wr_half,
    output logic                              need_data,
    output logic [1:0]                        half_full,
    output logic                              rd_half,
    output logic [$clog2(SLOTS_PER_HALF):0]   rd_slot,
    output logic                              load,
    output logic                              shift,
    output logic                              ff_en,
    output logic                              start,
    output logic                              overrun,
    output logic                              underrun
);

    localparam int                SLOT_W         = $clog2(SLOTS_PER_HALF);
    localparam logic [SLOT_W-1:0] SLOT_LAST      = SLOT_W'(SLOTS_PER_HALF - 1);
    localparam logic [SLOT_W-1:0] LONG_MASK      = SLOT_W'(LONG_EVERY - 1);
    localparam logic [7:0]        BIT_LAST       = 8'(BURST_BITS - 1);
    localparam logic [3:0]        GAP_SHORT_LAST = 4'(GAP_SHORT - 1);
    localparam logic [3:0]        GAP_LONG_LAST  = 4'(GAP_LONG - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        BURST = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t            state_r;
    logic [1:0]        half_full_r;
    logic              wr_half_r;
    logic              rd_half_r;
    logic [SLOT_W-1:0] slot_r;
    logic [7:0]        bit_cnt_r;
    logic [3:0]        gap_cnt_r;
    logic              need_data_r;
    logic              load_r;
    logic              shift_r;
    logic              ff_en_r;
    logic              start_r;
    logic              overrun_r;
    logic              underrun_r;

    logic              gap_last_s;
    logic              release_s;
    logic              accept_s;
    logic              reject_s;
    logic              underrun_set_s;
    logic [1:0]        rel_mask_s;
    logic [1:0]        acc_mask_s;
    logic [1:0]        half_full_nxt_s;
    logic              wr_half_nxt_s;

    // End-of-gap detection and write/release arbitration
    always_comb begin
        gap_last_s = 1'b0;
        if (state_r == GAP) begin
            if ((slot_r & LONG_MASK) == LONG_MASK) begin
                gap_last_s = (gap_cnt_r == GAP_LONG_LAST);
            end else begin
                gap_last_s = (gap_cnt_r == GAP_SHORT_LAST);
            end
        end else begin
            gap_last_s = 1'b0;
        end
        release_s       = gap_last_s && (slot_r == SLOT_LAST);
        // A half released this cycle may be refilled in the same cycle.
        accept_s        = half_wr && (!half_full_r[wr_half_r] ||
                                      (release_s && (rd_half_r == wr_half_r)));
        reject_s        = half_wr && !accept_s;
        underrun_set_s  = release_s && !half_full_r[~rd_half_r];
        rel_mask_s      = release_s ? (2'b01 << rd_half_r) : 2'b00;
        acc_mask_s      = accept_s  ? (2'b01 << wr_half_r) : 2'b00;
        half_full_nxt_s = (half_full_r & ~rel_mask_s) | acc_mask_s;
        wr_half_nxt_s   = wr_half_r ^ accept_s;
    end

    // Half occupancy, writer pointer and sticky error flags (set beats clear)
    always_ff @(posedge ff_clk) begin
        if (!ff_rst_n) begin
            half_full_r <= 2'b00;
            wr_half_r   <= 1'b0;
            need_data_r <= 1'b1;
            overrun_r   <= 1'b0;
            underrun_r  <= 1'b0;
        end else begin
            half_full_r <= half_full_nxt_s;
            wr_half_r   <= wr_half_nxt_s;
            need_data_r <= ~half_full_nxt_s[wr_half_nxt_s];
            if (reject_s) begin
                overrun_r <= 1'b1;
            end else if (clr_err) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end
            if (underrun_set_s) begin
                underrun_r <= 1'b1;
            end else if (clr_err) begin
                underrun_r <= 1'b0;
            end else begin
                underrun_r <= underrun_r;
            end
        end
    end

    // Drain FSM: strobes are registered together with the state they belong to
    always_ff @(posedge ff_clk) begin
        if (!ff_rst_n) begin
            state_r   <= IDLE;
            rd_half_r <= 1'b0;
            slot_r    <= '0;
            bit_cnt_r <= 8'd0;
            gap_cnt_r <= 4'd0;
            load_r    <= 1'b0;
            shift_r   <= 1'b0;
            ff_en_r   <= 1'b0;
            start_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (half_full_r[rd_half_r]) begin
                        state_r   <= LOAD;
                        load_r    <= 1'b1;
                        ff_en_r   <= 1'b1;
                        start_r   <= 1'b1;
                        bit_cnt_r <= 8'd1;
                    end else begin
                        state_r   <= IDLE;
                        load_r    <= 1'b0;
                        ff_en_r   <= 1'b0;
                    end
                end
                LOAD: begin
                    state_r <= BURST;
                    load_r  <= 1'b0;
                    shift_r <= 1'b1;
                    ff_en_r <= 1'b1;
                end
                BURST: begin
                    if (bit_cnt_r == BIT_LAST) begin
                        state_r   <= GAP;
                        gap_cnt_r <= 4'd0;
                        shift_r   <= 1'b0;
                        ff_en_r   <= 1'b0;
                    end else begin
                        bit_cnt_r <= bit_cnt_r + 8'd1;
                    end
                end
                GAP: begin
                    if (!gap_last_s) begin
                        gap_cnt_r <= gap_cnt_r + 4'd1;
                    end else if (slot_r != SLOT_LAST) begin
                        slot_r    <= slot_r + SLOT_W'(1);
                        state_r   <= LOAD;
                        load_r    <= 1'b1;
                        ff_en_r   <= 1'b1;
                        bit_cnt_r <= 8'd1;
                    end else begin
                        rd_half_r <= ~rd_half_r;
                        slot_r    <= '0;
                        if (half_full_r[~rd_half_r]) begin
                            state_r   <= LOAD;
                            load_r    <= 1'b1;
                            ff_en_r   <= 1'b1;
                            bit_cnt_r <= 8'd1;
                        end else begin
                            state_r   <= IDLE;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    load_r  <= 1'b0;
                    shift_r <= 1'b0;
                    ff_en_r <= 1'b0;
                end
            endcase
        end
    end

    assign wr_half   = wr_half_r;
    assign need_data = need_data_r;
    assign half_full = half_full_r;
    assign rd_half   = rd_half_r;
    assign rd_slot   = {rd_half_r, slot_r};
    assign load      = load_r;
    assign shift     = shift_r;
    assign ff_en     = ff_en_r;
    assign start     = start_r;
    assign overrun   = overrun_r;
    assign underrun  = underrun_r;

endmodule

// File: tb/tb_rx_burst_scheduler.sv
// Bench for rx_burst_scheduler: directed scenarios plus randomized traffic against a
// timeline model (drain position within a 1250-cycle half schedule).
module tb_rx_burst_scheduler;

    localparam int BB    = 148;
    localparam int DRAIN = 1250;

    logic       ff_clk   = 1'b0;
    logic       ff_rst_n = 1'b0;
    logic       half_wr  = 1'b0;
    logic       clr_err  = 1'b0;
    logic       wr_half, need_data, rd_half, load, shift, ff_en, start, overrun, underrun;
    logic [1:0] half_full;
    logic [3:0] rd_slot;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int off[9];

    rx_burst_scheduler dut (
        .ff_clk(ff_clk), .ff_rst_n(ff_rst_n), .half_wr(half_wr), .clr_err(clr_err),
        .wr_half(wr_half), .need_data(need_data), .half_full(half_full), .rd_half(rd_half),
        .rd_slot(rd_slot), .load(load), .shift(shift), .ff_en(ff_en), .start(start),
        .overrun(overrun), .underrun(underrun)
    );

    always #5 ff_clk = ~ff_clk;
    always @(posedge ff_clk) cyc <= cyc + 1;

    // Slot start offsets inside one half drain: burst plus gap (long after every 4th slot)
    initial begin
        off[0] = 0;
        for (int k = 0; k < 8; k++) off[k+1] = off[k] + BB + (((k % 4) == 3) ? 9 : 8);
    end

    // Reference model: which halves hold data, and where the reader is on its timeline
    logic [1:0] m_full;
    logic       m_wr, m_rd, m_act, m_start, m_ovr, m_und;
    int         m_pos;

    always @(posedge ff_clk) begin : model
        logic [1:0] f;
        logic       rel, ok, act, rd, st, uset;
        int         pos;
        if (!ff_rst_n) begin
            m_full <= 2'b00; m_wr <= 1'b0; m_rd <= 1'b0; m_act <= 1'b0; m_pos <= 0;
            m_start <= 1'b0; m_ovr <= 1'b0; m_und <= 1'b0;
        end else begin
            rel  = m_act && (m_pos == DRAIN - 1);
            ok   = half_wr && (!m_full[m_wr] || (rel && (m_rd == m_wr)));
            f    = m_full;
            if (rel) f[m_rd] = 1'b0;
            if (ok)  f[m_wr] = 1'b1;
            act = m_act; pos = m_pos; rd = m_rd; st = m_start; uset = 1'b0;
            if (m_act) begin
                if (rel) begin
                    rd = ~m_rd;
                    if (m_full[~m_rd]) pos = 0;
                    else begin act = 1'b0; uset = 1'b1; end
                end else begin
                    pos = m_pos + 1;
                end
            end else if (m_full[m_rd]) begin
                act = 1'b1; pos = 0;
            end
            if (act && pos == 0) st = 1'b1;
            m_full <= f; m_wr <= m_wr ^ ok; m_rd <= rd; m_act <= act; m_pos <= pos; m_start <= st;
            m_ovr <= (half_wr && !ok) ? 1'b1 : (clr_err ? 1'b0 : m_ovr);
            m_und <= uset ? 1'b1 : (clr_err ? 1'b0 : m_und);
        end
    end

    function automatic logic [14:0] exp_vec();
        int         slot = 0;
        logic       en, ld, sh;
        logic [2:0] s3;
        if (m_act) for (int k = 0; k < 8; k++) if (m_pos >= off[k]) slot = k;
        en = m_act && ((m_pos - off[slot]) < BB);
        ld = m_act && (m_pos == off[slot]);
        sh = en && !ld;
        s3 = 3'(slot);
        return {m_wr, ~m_full[m_wr], m_full, m_rd, m_rd, s3, ld, sh, en, m_start, m_ovr, m_und};
    endfunction

    logic [14:0] dut_vec;
    assign dut_vec = {wr_half, need_data, half_full, rd_half, rd_slot, load, shift, ff_en,
                      start, overrun, underrun};

    task automatic do_reset();
        @(negedge ff_clk);
        ff_rst_n = 1'b0; half_wr = 1'b0; clr_err = 1'b0;
        repeat (2) @(negedge ff_clk);
        ff_rst_n = 1'b1;
    endtask

    task automatic pulse_wr();
        half_wr = 1'b1;
        @(negedge ff_clk);
        half_wr = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (1000) begin
            @(negedge ff_clk);
            n_chk++;
            if (ff_en !== 1'b0 || need_data !== 1'b1 || wr_half !== 1'b0 || start !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle t=%0t ff_en=%b need_data=%b wr_half=%b start=%b (want 0 1 0 0)",
                         $time, ff_en, need_data, wr_half, start);
            end
            n_chk++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL model_reset t=%0t dut=%h exp=%h", $time, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_first_slot();
        int hi = 0, lo = 0;
        do_reset();
        pulse_wr();
        n_chk++;
        if (half_full !== 2'b01 || wr_half !== 1'b1) begin
            n_fail++;
            $display("FAIL first_fill half_full=%b wr_half=%b (want 01 1)", half_full, wr_half);
        end
        @(negedge ff_clk);
        n_chk++;
        if (load !== 1'b1 || rd_slot !== 4'd0) begin
            n_fail++;
            $display("FAIL first_load load=%b rd_slot=%0d (want 1 0)", load, rd_slot);
        end
        while (ff_en === 1'b1 && hi < 400) begin hi++; @(negedge ff_clk); end
        while (ff_en === 1'b0 && lo < 40)  begin lo++; @(negedge ff_clk); end
        n_chk++;
        if (hi != BB) begin n_fail++; $display("FAIL burst_len got %0d want %0d", hi, BB); end
        n_chk++;
        if (lo != 8) begin n_fail++; $display("FAIL gap0_len got %0d want 8", lo); end
        n_chk++;
        if (load !== 1'b1 || rd_slot !== 4'd1) begin
            n_fail++;
            $display("FAIL second_load load=%b rd_slot=%0d (want 1 1)", load, rd_slot);
        end
    endtask

    task automatic test_half_drain();
        logic en_a[DRAIN];
        int   runs[$];
        int   k = 0, len, want;
        logic cur;
        do_reset();
        pulse_wr();
        while (load !== 1'b1 && k < 10) begin k++; @(negedge ff_clk); end
        n_chk++;
        if (load !== 1'b1) begin n_fail++; $display("FAIL drain_load_timeout load=%b want 1", load); end
        for (int i = 0; i < DRAIN; i++) begin
            en_a[i] = ff_en;
            n_chk++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL model_drain t=%0t dut=%h exp=%h", $time, dut_vec, exp_vec());
            end
            @(negedge ff_clk);
        end
        n_chk++;
        if (half_full !== 2'b00 || rd_half !== 1'b1 || underrun !== 1'b1 || need_data !== 1'b1 ||
            ff_en !== 1'b0 || load !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_release hf=%b rd_half=%b und=%b need=%b ff_en=%b load=%b (want 00 1 1 1 0 0)",
                     half_full, rd_half, underrun, need_data, ff_en, load);
        end
        cur = en_a[0]; len = 1;
        for (int i = 1; i < DRAIN; i++) begin
            if (en_a[i] == cur) len++;
            else begin runs.push_back(len); cur = en_a[i]; len = 1; end
        end
        runs.push_back(len);
        n_chk++;
        if (runs.size() != 16) begin
            n_fail++;
            $display("FAIL drain_run_count got %0d want 16", runs.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                want = ((i % 2) == 0) ? BB : ((((i / 2) % 4) == 3) ? 9 : 8);
                n_chk++;
                if (runs[i] != want) begin
                    n_fail++;
                    $display("FAIL drain_run%0d got %0d want %0d", i, runs[i], want);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int   slots[$];
        int   k = 0;
        logic und_seen = 1'b0;
        do_reset();
        half_wr = 1'b1;
        @(negedge ff_clk);
        @(negedge ff_clk);
        half_wr = 1'b0;
        while (load !== 1'b1 && k < 10) begin k++; @(negedge ff_clk); end
        for (int i = 0; i < 2 * DRAIN; i++) begin
            if (load === 1'b1) slots.push_back(int'(rd_slot));
            if (underrun !== 1'b0) und_seen = 1'b1;
            n_chk++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL model_b2b t=%0t dut=%h exp=%h", $time, dut_vec, exp_vec());
            end
            @(negedge ff_clk);
        end
        n_chk++;
        if (und_seen) begin n_fail++; $display("FAIL b2b_underrun got 1 want 0 during drain"); end
        n_chk++;
        if (slots.size() != 16) begin
            n_fail++;
            $display("FAIL b2b_load_count got %0d want 16", slots.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                n_chk++;
                if (slots[i] != i) begin
                    n_fail++;
                    $display("FAIL b2b_slot%0d got %0d want %0d", i, slots[i], i);
                end
            end
        end
        n_chk++;
        if (underrun !== 1'b1 || half_full !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b_end underrun=%b half_full=%b (want 1 00)", underrun, half_full);
        end
    endtask

    task automatic test_overrun();
        int t0;
        int k = 0;
        do_reset();
        half_wr = 1'b1;
        @(negedge ff_clk);
        @(negedge ff_clk);
        n_chk++;
        if (load !== 1'b1) begin n_fail++; $display("FAIL ovr_load load=%b want 1", load); end
        t0 = cyc;
        @(negedge ff_clk);
        half_wr = 1'b0;
        n_chk++;
        if (overrun !== 1'b1 || half_full !== 2'b11 || wr_half !== 1'b0 || need_data !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_reject ovr=%b hf=%b wr_half=%b need=%b (want 1 11 0 0)",
                     overrun, half_full, wr_half, need_data);
        end
        clr_err = 1'b1; @(negedge ff_clk); clr_err = 1'b0;
        n_chk++;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear got %b want 0", overrun); end
        half_wr = 1'b1; clr_err = 1'b1; @(negedge ff_clk); half_wr = 1'b0; clr_err = 1'b0;
        n_chk++;
        if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set_wins got %b want 1", overrun); end
        clr_err = 1'b1; @(negedge ff_clk); clr_err = 1'b0;
        n_chk++;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear2 got %b want 0", overrun); end
        while (cyc < t0 + DRAIN - 1 && k < 2 * DRAIN) begin k++; @(negedge ff_clk); end
        n_chk++;
        if (ff_en !== 1'b0 || rd_slot !== 4'd7 || half_full !== 2'b11) begin
            n_fail++;
            $display("FAIL ovr_last_gap ff_en=%b rd_slot=%0d hf=%b (want 0 7 11)", ff_en, rd_slot, half_full);
        end
        half_wr = 1'b1; @(negedge ff_clk); half_wr = 1'b0;
        n_chk++;
        if (overrun !== 1'b0 || half_full !== 2'b11 || wr_half !== 1'b1 || rd_half !== 1'b1 ||
            load !== 1'b1 || underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL refill_on_release ovr=%b hf=%b wr=%b rd=%b load=%b und=%b (want 0 11 1 1 1 0)",
                     overrun, half_full, wr_half, rd_half, load, underrun);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        pulse_wr();
        @(negedge ff_clk);
        repeat (70) @(negedge ff_clk);
        n_chk++;
        if (ff_en !== 1'b1 || start !== 1'b1 || shift !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_burst_pre ff_en=%b start=%b shift=%b (want 1 1 1)", ff_en, start, shift);
        end
        ff_rst_n = 1'b0;
        @(negedge ff_clk);
        n_chk++;
        if (ff_en !== 1'b0 || half_full !== 2'b00 || start !== 1'b0 || rd_slot !== 4'd0 ||
            need_data !== 1'b1 || shift !== 1'b0 || load !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_burst_reset ff_en=%b hf=%b start=%b rd_slot=%0d need=%b shift=%b load=%b",
                     ff_en, half_full, start, rd_slot, need_data, shift, load);
        end
        ff_rst_n = 1'b1;
    endtask

    task automatic test_random();
        do_reset();
        repeat (8000) begin
            half_wr  = ($urandom_range(0, 499) == 0);
            clr_err  = ($urandom_range(0, 199) == 0);
            ff_rst_n = ($urandom_range(0, 2999) != 0);
            @(negedge ff_clk);
            n_chk++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL model_random t=%0t dut=%h exp=%h", $time, dut_vec, exp_vec());
            end
        end
        half_wr = 1'b0; clr_err = 1'b0; ff_rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_first_slot();
        test_half_drain();
        test_back_to_back();
        test_overrun();
        test_reset_mid_burst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
